mandel_pixel_scheduler: RTL
===========================

// Module: mandel_pixel_scheduler
// PURPOSE
//  Walks every pixel of a frame and dispatches its (x,y) to NUM_CORES shared Mandelbrot
//  iteration cores. Collects each core's 8-bit iteration count and writes it to the
//  framebuffer write port. Sits between the frame-start control and the iteration cores
//  and framebuffer, so the display side only reads finished iteration counts.
// PARAMETERS
//  NUM_CORES   2     iteration cores shared by the scheduler (1..8)
//  H_RES       640   pixels per line
//  V_RES       480   lines per frame
//  ADDR_W      19    framebuffer address width; must satisfy 2^ADDR_W >= H_RES*V_RES
// PORTS
//  clk         in   1            system clock, rising edge
//  rst         in   1            asynchronous, active-low reset
//  start       in   1            one-cycle pulse: begin a frame (ignored while busy)
//  busy        out  1            frame in progress
//  frame_done  out  1            one-cycle pulse after the last pixel is written
//  core_start  out  NUM_CORES    one-hot, one-cycle: core i latches core_x/core_y
//  core_x      out  10           pixel x for the core being started
//  core_y      out  10           pixel y for the core being started
//  core_done   in   NUM_CORES    one-cycle pulse per core: result valid on core_iters
//  core_iters  in   8*NUM_CORES  core i result in bits [8i+7:8i]
//  fb_we       out  1            framebuffer write valid
//  fb_addr     out  ADDR_W       y*H_RES + x of the written pixel
//  fb_data     out  8            iteration count
//  fb_ready    in   1            framebuffer accepts the write when fb_we && fb_ready
// BEHAVIOUR
//  - Reset: busy=0, frame_done=0, core_start=0, core_x=0, core_y=0, fb_we=0, fb_addr=0,
//    fb_data=0; all slots IDLE; pixel counters 0. Reset mid-frame aborts the frame; no
//    further writes; in-flight core results are discarded.
//  - Top FSM: IDLE -start-> DISPATCH -last pixel started-> DRAIN -all slots IDLE and
//    no write pending-> IDLE with frame_done=1 for one cycle. start outside IDLE ignored.
//  - Per-core slot FSM: IDLE -core_start-> RUN -core_done-> RESULT -write accepted-> IDLE.
//    Slot stores fb_addr (computed at dispatch) and captured iters.
//  - Dispatch: in DISPATCH, each cycle start the lowest-index IDLE slot (max one per cycle);
//    core_start, core_x, core_y registered; first core_start is the cycle after start.
//    Raster order: x increments; at x=H_RES-1, x wraps to 0 and y increments.
//  - A slot freed by an accepted write in cycle n is dispatchable in cycle n+1.
//  - core_done for a slot not in RUN is ignored. Results may complete out of order.
//  - Writeback: round-robin over RESULT slots, pointer advances past the winner after
//    acceptance. fb_we/fb_addr/fb_data registered and held stable until fb_ready=1; next
//    write may be presented the cycle after acceptance (one write per cycle max).
//  - fb_ready=0 indefinitely: slots stay in RESULT, dispatch stalls when no slot IDLE.
//  - Address: fb_addr = y*H_RES + x, computed with a running counter (+1 per dispatch),
//    no multiplier; wraps to 0 at frame start.
//  - busy=1 from the cycle after start until the cycle frame_done is asserted (inclusive
//    deassert: busy=0 in the frame_done cycle).
// CONFIGURATION
//  MANDEL_SCHED_STATS_EN defined: adds output frame_cycles[31:0]; internal counter clears
//    at start, increments every busy cycle, and is copied to frame_cycles on frame_done;
//    frame_cycles resets to 0 and holds between frames.
//  Not defined: port and counter absent; all other behaviour identical.
// TESTING  (H_RES=4, V_RES=2, NUM_CORES=2, fixed-latency core model unless noted)
//  - Basic frame: start, core latency 5, iters=x+4y -> 8 writes, addr 0..7 each exactly
//    once, data==addr, frame_done pulses once, busy low after.
//  - Out-of-order: core0 latency 9, core1 latency 2 -> writes arrive out of addr order,
//    all 8 present, no duplicates, no core_start to a RUN slot.
//  - Backpressure: fb_ready low 20 cycles mid-frame -> fb_we/addr/data stable while
//    stalled, no core_start while both slots RESULT, frame completes after release.
//  - Ignored inputs: start during busy and spurious core_done to IDLE slot -> no
//    restart, no extra write, exactly 8 writes.
//  - Reset mid-frame: rst low after 3 writes -> all outputs 0 immediately; new start
//    produces full 8-write frame beginning at addr 0.
//  - STATS_EN: latency 5, fb_ready=1 -> frame_cycles equals measured busy-cycle count.

Source files
------------

// File: rtl/mandel_pixel_scheduler.sv
// Raster-order pixel dispatcher for a pool of Mandelbrot iteration cores, with round-robin
// framebuffer writeback. Define MANDEL_SCHED_STATS_EN to add the frame_cycles counter output.
module mandel_pixel_scheduler #(
    parameter int unsigned NUM_CORES = 2,
    parameter int unsigned H_RES     = 640,
    parameter int unsigned V_RES     = 480,
    parameter int unsigned ADDR_W    = 19
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic                     busy,
    output logic                     frame_done,
    output logic [NUM_CORES-1:0]     core_start,
    output logic [9:0]               core_x,
    output logic [9:0]               core_y,
    input  logic [NUM_CORES-1:0]     core_done,
    input  logic [8*NUM_CORES-1:0]   core_iters,
    output logic                     fb_we,
    output logic [ADDR_W-1:0]        fb_addr,
    output logic [7:0]               fb_data,
    input  logic                     fb_ready
`ifdef MANDEL_SCHED_STATS_EN
    ,
    output logic [31:0]              frame_cycles
`endif
);

    localparam int unsigned IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    typedef enum logic [1:0] {T_IDLE, T_DISPATCH, T_DRAIN} top_state_t;
    typedef enum logic [1:0] {SL_IDLE, SL_RUN, SL_RESULT} slot_state_t;

    top_state_t        state, state_nxt;
    slot_state_t       slot_st    [NUM_CORES];
    logic [ADDR_W-1:0] slot_addr  [NUM_CORES];
    logic [7:0]        slot_iters [NUM_CORES];

    logic [9:0]        px, py;
    logic [ADDR_W-1:0] pix_addr;
    logic [IDX_W-1:0]  wb_slot, rr_ptr;

    logic              disp_en, disp_found, last_pix, all_idle, frame_end;
    logic              wb_accept, wb_found, wb_load;
    logic [IDX_W-1:0]  disp_idx, wb_idx, wb_base, wb_after, wb_cand;

    // Next-state, dispatch grant (lowest IDLE slot) and writeback pick (round-robin RESULT slot)
    always_comb begin
        state_nxt  = state;
        disp_found = 1'b0;
        disp_idx   = '0;
        wb_found   = 1'b0;
        wb_idx     = '0;
        wb_cand    = '0;
        all_idle   = 1'b1;
        wb_accept  = fb_we && fb_ready;
        last_pix   = (px == 10'(H_RES - 1)) && (py == 10'(V_RES - 1));
        wb_after   = (wb_slot == IDX_W'(NUM_CORES - 1)) ? '0 : wb_slot + IDX_W'(1);
        wb_base    = wb_accept ? wb_after : rr_ptr;

        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (slot_st[i] == SL_IDLE) begin
                disp_found = 1'b1;
                disp_idx   = IDX_W'(i);
            end else begin
                all_idle = 1'b0;
            end
        end

        // Descending offset so the candidate closest to wb_base wins; skip the slot being written
        for (int k = NUM_CORES - 1; k >= 0; k--) begin
            wb_cand = IDX_W'((32'(wb_base) + 32'(k)) % NUM_CORES);
            if ((slot_st[wb_cand] == SL_RESULT) && !(fb_we && (wb_slot == wb_cand))) begin
                wb_found = 1'b1;
                wb_idx   = wb_cand;
            end
        end
        wb_load = wb_found && (!fb_we || wb_accept);

        disp_en = disp_found && ((state == T_DISPATCH) || ((state == T_IDLE) && start));

        case (state)
            T_IDLE:     if (start) state_nxt = (disp_en && last_pix) ? T_DRAIN : T_DISPATCH;
            T_DISPATCH: if (disp_en && last_pix) state_nxt = T_DRAIN;
            T_DRAIN:    if (all_idle && !fb_we) state_nxt = T_IDLE;
            default:    state_nxt = T_IDLE;
        endcase
        frame_end = (state == T_DRAIN) && (state_nxt == T_IDLE);
    end

    // Top state, dispatch outputs and raster counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= T_IDLE;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            core_start <= '0;
            core_x     <= '0;
            core_y     <= '0;
            px         <= '0;
            py         <= '0;
            pix_addr   <= '0;
        end else begin
            state      <= state_nxt;
            busy       <= (state_nxt != T_IDLE);
            frame_done <= frame_end;
            core_start <= disp_en ? (NUM_CORES'(1) << disp_idx) : '0;
            if (disp_en) begin
                core_x <= px;
                core_y <= py;
                if (last_pix) begin
                    px       <= '0;
                    py       <= '0;
                    pix_addr <= '0;
                end else begin
                    pix_addr <= pix_addr + ADDR_W'(1);
                    if (px == 10'(H_RES - 1)) begin
                        px <= '0;
                        py <= py + 10'd1;
                    end else begin
                        px <= px + 10'd1;
                    end
                end
            end
        end
    end

    // Per-core slot tracking: address fixed at dispatch, iteration count captured on done
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_CORES; i++) begin
                slot_st[i]    <= SL_IDLE;
                slot_addr[i]  <= '0;
                slot_iters[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CORES; i++) begin
                case (slot_st[i])
                    SL_IDLE: if (disp_en && (disp_idx == IDX_W'(i))) begin
                        slot_st[i]   <= SL_RUN;
                        slot_addr[i] <= pix_addr;
                    end
                    SL_RUN: if (core_done[i]) begin
                        slot_st[i]    <= SL_RESULT;
                        slot_iters[i] <= core_iters[8*i +: 8];
                    end
                    SL_RESULT: if (wb_accept && (wb_slot == IDX_W'(i))) slot_st[i] <= SL_IDLE;
                    default: slot_st[i] <= SL_IDLE;
                endcase
            end
        end
    end

    // Framebuffer write register: held until accepted, reloaded in the accept cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fb_we   <= 1'b0;
            fb_addr <= '0;
            fb_data <= '0;
            wb_slot <= '0;
            rr_ptr  <= '0;
        end else begin
            if (wb_accept) begin
                fb_we  <= 1'b0;
                rr_ptr <= wb_after;
            end
            if (wb_load) begin
                fb_we   <= 1'b1;
                fb_addr <= slot_addr[wb_idx];
                fb_data <= slot_iters[wb_idx];
                wb_slot <= wb_idx;
            end
        end
    end

`ifdef MANDEL_SCHED_STATS_EN
    logic [31:0] cyc_cnt;

    // Busy-cycle counter; the final busy cycle is added as the result is copied out
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cyc_cnt      <= '0;
            frame_cycles <= '0;
        end else begin
            if ((state == T_IDLE) && start) begin
                cyc_cnt <= '0;
            end else if (busy) begin
                cyc_cnt <= cyc_cnt + 32'd1;
            end
            if (frame_end) frame_cycles <= cyc_cnt + 32'd1;
        end
    end
`endif

endmodule
